// File: rtl/system_cpu_debug_cmd_sync.sv
// Synchronises virtual-JTAG update strobes into clk_sys and queues {ir, sr} debug commands in a small FIFO.
// Optional drop counter output ovf_count is built when DEBUG_CMD_OVF_COUNT_EN is defined.
module system_cpu_debug_cmd_sync #(
    parameter int DATA_W = 38,
    parameter int IR_W   = 2,
    parameter int DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 vs_udr,
    input  logic                 vs_uir,
    input  logic [IR_W-1:0]      ir_in,
    input  logic [DATA_W-1:0]    sr,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [IR_W-1:0]      cmd_ir,
    output logic [DATA_W-1:0]    cmd_data,
    output logic [DATA_W-1:0]    jdo,
    output logic [(2**IR_W)-1:0] take_action,
    output logic                 uir_pulse,
    output logic [IR_W-1:0]      ir_latched,
    output logic                 overflow,
    input  logic                 clr_ovf
`ifdef DEBUG_CMD_OVF_COUNT_EN
    ,
    output logic [7:0]           ovf_count
`endif
);

    localparam int NCH = 2**IR_W;
    localparam int AW  = $clog2(DEPTH);
    localparam int EW  = IR_W + DATA_W;

    logic [2:0]    udr_s;
    logic [2:0]    uir_s;
    logic          udr_rise;
    logic          uir_rise;
    logic [EW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push_ok;
    logic          drop;
    logic [NCH-1:0] action_bit;

    // Chains reset high so a strobe already high at reset release is not seen as a rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            udr_s <= 3'b111;
            uir_s <= 3'b111;
        end else begin
            udr_s <= {udr_s[1:0], vs_udr};
            uir_s <= {uir_s[1:0], vs_uir};
        end
    end

    assign udr_rise = udr_s[1] & ~udr_s[2];
    assign uir_rise = uir_s[1] & ~uir_s[2];

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign cmd_valid = ~empty;
    assign pop       = cmd_valid & cmd_ready;
    // A pop frees the slot at the same edge, so a push into a full FIFO still lands.
    assign push_ok   = udr_rise & (~full | pop);
    assign drop      = udr_rise & full & ~pop;

    assign {cmd_ir, cmd_data} = mem[rd_ptr[AW-1:0]];
    assign action_bit = {{(NCH-1){1'b0}}, 1'b1} << cmd_ir;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= {ir_in, sr};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            jdo         <= '0;
            take_action <= '0;
            uir_pulse   <= 1'b0;
            ir_latched  <= '0;
            overflow    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                jdo         <= cmd_data;
                take_action <= action_bit;
            end else begin
                take_action <= '0;
            end
            uir_pulse <= uir_rise;
            if (uir_rise) begin
                ir_latched <= ir_in;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef DEBUG_CMD_OVF_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_count <= 8'd0;
        end else if (drop && clr_ovf) begin
            ovf_count <= 8'd1;
        end else if (drop) begin
            if (ovf_count != 8'hFF) begin
                ovf_count <= ovf_count + 8'd1;
            end
        end else if (clr_ovf) begin
            ovf_count <= 8'd0;
        end
    end
`endif

endmodule

// File: doc/system_cpu_debug_cmd_sync.md
SYSTEM_CPU_DEBUG_CMD_SYNC -- requirements
Module: system_cpu_debug_cmd_sync

Interface
REQ-001 The module SHALL have parameter DATA_W, default 38, meaning debug shift-register (sr) width.
REQ-002 The module SHALL have parameter IR_W, default 2, meaning virtual-JTAG instruction width; the number of action channels is NCH = 2**IR_W.
REQ-003 The module SHALL have parameter DEPTH, default 4, meaning command FIFO entries, power of two, minimum 2.
REQ-004 The module SHALL run on one clock and one asynchronous, active-high reset.
REQ-005 Port clk, input, 1 bit: system clock; all state updates on the rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous active-high reset.
REQ-007 Port vs_udr, input, 1 bit: update-DR strobe, asynchronous to clk.
REQ-008 Port vs_uir, input, 1 bit: update-IR strobe, asynchronous to clk.
REQ-009 Port ir_in, input, IR_W bits: current instruction; stable while vs_udr or vs_uir is high.
REQ-010 Port sr, input, DATA_W bits: shifted data; stable while vs_udr is high.
REQ-011 Port cmd_valid, output, 1 bit: FIFO head is valid.
REQ-012 Port cmd_ready, input, 1 bit: consumer accepts the head.
REQ-013 Port cmd_ir, output, IR_W bits: instruction of the head entry.
REQ-014 Port cmd_data, output, DATA_W bits: data of the head entry.
REQ-015 Port jdo, output, DATA_W bits: registered data of the last popped command.
REQ-016 Port take_action, output, NCH bits: one-hot, one-cycle pulse per popped command, indexed by its IR.
REQ-017 Port uir_pulse, output, 1 bit: one-cycle pulse per synchronised vs_uir rise.
REQ-018 Port ir_latched, output, IR_W bits: ir_in captured at the uir_pulse detection cycle.
REQ-019 Port overflow, output, 1 bit: sticky flag, set when a command is dropped.
REQ-020 Port clr_ovf, input, 1 bit: clears overflow (and the counter of REQ-036).

Function
REQ-021 vs_udr and vs_uir SHALL each pass through a three-flop chain (s1, s2, s3); a rise is detected when s2=1 and s3=0.
REQ-022 A detected udr rise SHALL push {ir_in, sr} into the FIFO at the next clk edge; cmd_valid is high no later than 4 clk edges after vs_udr rises.
REQ-023 A detected uir rise SHALL pulse uir_pulse for exactly one cycle and load ir_latched at the same edge.
REQ-024 The FIFO SHALL be first-in first-out; cmd_ir/cmd_data show the head whenever cmd_valid=1 and are don't-care otherwise.
REQ-025 A pop SHALL occur at an edge where cmd_valid=1 and cmd_ready=1; cmd_valid, cmd_ir and cmd_data are held stable until that pop.
REQ-026 On a pop, at the same edge, jdo SHALL load cmd_data and take_action SHALL set bit cmd_ir alone for one cycle; all other cycles take_action=0.
REQ-027 A push when the FIFO is full without a simultaneous pop SHALL be dropped, leave the FIFO unchanged, and set overflow.
REQ-028 A push and a pop at the same edge when full SHALL both be performed; overflow is not set.
REQ-029 A push and a pop at the same edge when not full and not empty SHALL both be performed; occupancy is unchanged.
REQ-030 Read/write pointers SHALL be log2(DEPTH)+1 bits, wrap modulo 2*DEPTH, full = MSB differ and rest equal, empty = equal.
REQ-031 If clr_ovf=1 and a drop occur at the same edge, overflow SHALL end the edge set (set wins).

Reset
REQ-032 While reset=1: FIFO empty, cmd_valid=0, take_action=0, uir_pulse=0, jdo=0, ir_latched=0, overflow=0.
REQ-033 Synchroniser flops SHALL reset to 1, so a strobe held high across reset release produces no capture.
REQ-034 Reset asserted mid-operation SHALL discard all queued commands immediately (asynchronously).

Configuration
REQ-035 Macro DEBUG_CMD_OVF_COUNT_EN SHALL select the optional drop counter.
REQ-036 With it defined: output ovf_count, 8 bits, increments on each dropped command, saturates at 255, reset/clr_ovf to 0 (increment wins over clr_ovf at the same edge, giving 1). Without it: the port and logic are absent; the overflow flag alone remains.

Verification
REQ-037 Reset release with vs_udr held high, then held 10 cycles -> cmd_valid stays 0.
REQ-038 Defaults; vs_udr pulse with ir_in=2, sr=38'h15_A5A5_A5A5, cmd_ready=1 -> within 4 edges: jdo=38'h15_A5A5_A5A5, take_action=4'b0100 for exactly one cycle.
REQ-039 cmd_ready=0, five udr pulses with sr=1..5 -> entries 1..4 queued, overflow=1, ovf_count=1 if enabled; then cmd_ready=1 -> pops 1,2,3,4 in order.
REQ-040 FIFO full, cmd_ready=1, udr rise detected on the pop edge -> both performed, overflow stays 0, occupancy remains 4.
REQ-041 vs_uir pulse with ir_in=3 -> one uir_pulse cycle, ir_latched=3, FIFO unchanged.
REQ-042 Reset asserted with 3 entries queued -> cmd_valid=0 immediately; after release no stale entry appears.
